fetch_unit: RTL
===============

# fetch_unit

Multi-cycle instruction fetch stage sitting directly upstream of the decode/controller and NPC logic. It owns the fetch PC, issues word reads to an instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small queue that the downstream stage drains with a valid/ready handshake. Branch/jump redirects from NPC flush the queue and restart fetch; an in-flight read is never abandoned but its data is discarded.

## Interface
- `RESET_PC`, 30'h0000_0C00: word address, bits [31:2], fetched first after reset.
- `DEPTH`, 2: instruction queue entries (2..8).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared immediately while low.
- `imem_req`  out  1  read request, registered.
- `imem_addr`  out  30  word address [31:2], registered, stable while `imem_req`=1.
- `imem_ack`  in  1  one-cycle pulse; read complete; only legal while `imem_req`=1.
- `imem_data`  in  32  instruction word, valid in the `imem_ack` cycle.
- `redirect`  in  1  one-cycle pulse from NPC: flush and refetch.
- `redirect_pc`  in  30  new word address, valid with `redirect`.
- `instr_valid`  out  1  queue head valid.
- `instr`  out  32  queue head instruction.
- `instr_pc`  out  30  word address of queue head.
- `instr_ready`  in  1  downstream accepts head.

## Operation
- State: `fpc` (next address to request), `req`/`addr` registers, `drop` flag, queue of {pc, instr} with occupancy count 0..DEPTH.
- Pop: `instr_valid && instr_ready` at an edge removes head.
- Push: `imem_ack && !drop` at an edge writes {`imem_addr`, `imem_data`} to tail; `fpc` becomes `imem_addr`+1 (modulo 2^30, 30'h3FFF_FFFF wraps to 0).
- Launch: at an edge where no request remains outstanding afterwards (req=0, or ack this cycle) and occupancy after this edge's push/pop is < DEPTH: `imem_req`<=1, `imem_addr`<=`fpc` (post-update value). Otherwise on ack `imem_req`<=0.
- At most one request outstanding; the launch rule guarantees a free entry when its ack arrives, so push never sees a full queue.
- Redirect (priority over push/pop): queue cleared, `fpc`<=`redirect_pc`.
  - No request outstanding, or ack this cycle: the acked data is discarded; launch at this edge with `imem_addr`<=`redirect_pc`; `drop`<=0.
  - Request outstanding, no ack: `imem_req`/`imem_addr` held; `drop`<=1. When that ack arrives, data discarded, `drop`<=0, launch `fpc` at same edge.
  - Redirect while `drop`=1: only `fpc` updated; `drop` stays 1.
- Redirect coincident with pop: head counts as consumed downstream; queue cleared regardless.
- `instr_valid` = occupancy != 0; `instr`/`instr_pc` show head, hold stable while `instr_valid && !instr_ready`.
- Empty queue: `instr`/`instr_pc` hold last values (no X).

## Timing
- Reset (async, while low): `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=32'h0, `instr_pc`=RESET_PC, occupancy 0, `drop`=0, `fpc`=RESET_PC.
- First rising edge after `reset` goes high: `imem_req`=1, `imem_addr`=RESET_PC.
- Ack latency from memory is arbitrary (≥1 cycle after req rises).
- Ack at edge t: entry visible (`instr_valid`=1) after t; next request launched at t (back-to-back) if space.
- Zero-wait memory (ack every cycle) with `instr_ready`=1: one instruction per cycle sustained.
- Redirect at edge t with idle memory port: request for `redirect_pc` after t; with single-cycle ack, `instr_valid` for it after t+1.
- Reset asserted mid-transaction: request dropped immediately; memory must tolerate `imem_req` falling without ack.

## Test plan
- Reset, zero-wait memory returning `{2'b0,addr}`, `instr_ready`=1 -> `instr_pc` 0xC00,0xC01,0xC02… on consecutive cycles, `instr` matches.
- `instr_ready`=0 for 6 cycles, zero-wait memory -> exactly DEPTH=2 entries queued, `imem_req`=0, head stable; on ready=1 stream resumes with no gap or skip.
- Memory with 3-cycle ack latency, redirect to 0x40 one cycle after request for 0xC01 -> `imem_addr` stays 0xC01 until ack, 0xC01 data never appears, next `instr_pc`=0x40.
- Redirect to 0x100 in same cycle as ack for 0xC03 and pop -> 0xC03 discarded, queue empty, next request 0x100, first `instr_pc`=0x100.
- Redirect to 0x3FFF_FFFF -> `instr_pc` 0x3FFF_FFFF then 0x0000_0000.
- Assert `reset` low mid-request with 2 queued entries -> all outputs to reset values same cycle; after release, refetch from 0xC00.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC, issues one word read at a time to instruction memory
// over a req/ack handshake, and buffers returned {pc, instr} pairs in a small
// circular queue drained downstream with valid/ready. A redirect flushes the
// queue and restarts fetch; an in-flight read is allowed to complete but its
// data is dropped.
module fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [29:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Circular pointer increment that also handles non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Architectural state
    logic [29:0]      fpc_q, fpc_d;
    logic             req_q, req_d;
    logic [29:0]      addr_q, addr_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic             valid_q, valid_d;
    logic [31:0]      head_ins_q, head_ins_d;
    logic [29:0]      head_pc_q, head_pc_d;
    logic [29:0]      pc_mem_q  [DEPTH];
    logic [31:0]      ins_mem_q [DEPTH];

    logic ack_s;
    logic pop_s;
    logic push_s;
    logic port_free_s;

    // Next-state computation: redirect, push/pop, launch and the next queue head.
    always_comb begin
        fpc_d      = fpc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        head_ins_d = head_ins_q;
        head_pc_d  = head_pc_q;
        push_s     = 1'b0;

        // An ack is only meaningful while a request is actually outstanding.
        ack_s       = imem_ack & req_q;
        pop_s       = (cnt_q != {CNT_W{1'b0}}) & instr_ready;
        // Port is free after this edge when nothing is outstanding or it completes now.
        port_free_s = ~req_q | ack_s;

        if (redirect) begin
            // Flush wins over push/pop; a coincident pop counts as consumed.
            fpc_d = redirect_pc;
            cnt_d = {CNT_W{1'b0}};
            rd_d  = {PTR_W{1'b0}};
            wr_d  = {PTR_W{1'b0}};
            if (port_free_s) begin
                req_d  = 1'b1;
                addr_d = redirect_pc;
                drop_d = 1'b0;
            end else begin
                // Read still in flight: keep it on the bus, discard its data later.
                drop_d = 1'b1;
            end
        end else begin
            if (ack_s && drop_q) begin
                drop_d = 1'b0;
            end else if (ack_s) begin
                push_s = 1'b1;
                fpc_d  = addr_q + 30'd1;
                wr_d   = ptr_inc(wr_q);
            end else begin
                drop_d = drop_q;
            end

            if (pop_s) begin
                rd_d = ptr_inc(rd_q);
            end else begin
                rd_d = rd_q;
            end

            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase

            // Only launch when the returning data is guaranteed a free entry.
            if (port_free_s && (cnt_d < DEPTH_C)) begin
                req_d  = 1'b1;
                addr_d = fpc_d;
            end else if (ack_s) begin
                req_d = 1'b0;
            end else begin
                req_d = req_q;
            end

            // Head registers track the new head; they hold when the queue empties.
            if (cnt_d == {CNT_W{1'b0}}) begin
                head_ins_d = head_ins_q;
                head_pc_d  = head_pc_q;
            end else if ((cnt_q == {CNT_W{1'b0}}) ||
                         (pop_s && (cnt_q == CNT_W'(1)))) begin
                head_ins_d = imem_data;
                head_pc_d  = addr_q;
            end else begin
                head_ins_d = ins_mem_q[rd_d];
                head_pc_d  = pc_mem_q[rd_d];
            end
        end

        valid_d = (cnt_d != {CNT_W{1'b0}});
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            drop_q     <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            rd_q       <= {PTR_W{1'b0}};
            wr_q       <= {PTR_W{1'b0}};
            valid_q    <= 1'b0;
            head_ins_q <= 32'h0000_0000;
            head_pc_q  <= RESET_PC;
        end else begin
            fpc_q      <= fpc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            valid_q    <= valid_d;
            head_ins_q <= head_ins_d;
            head_pc_q  <= head_pc_d;
        end
    end

    // Queue storage: write the returned word and its address at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= 30'h0000_0000;
                ins_mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_q[wr_q]  <= addr_q;
            ins_mem_q[wr_q] <= imem_data;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = head_ins_q;
    assign instr_pc    = head_pc_q;

endmodule
